// File: rtl/hwpf_pkg.sv
// hwpf_pkg: request bundle, line-address helpers and default geometry
// shared by the prefetch arbiter and the prefetchers.
package hwpf_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_BYTES_DEF = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef logic [ADDR_W-1:0] hwpf_addr_t;
  typedef logic [ADDR_W-1:0] hwpf_line_t;
  typedef logic [3:0]        hpdcache_op_t;
  typedef logic [2:0]        hpdcache_sid_t;
  typedef logic [3:0]        hpdcache_tid_t;

  typedef struct packed {
    hwpf_addr_t    addr;
    hpdcache_op_t  op;
    logic          uncacheable;
    logic          need_rsp;
    hpdcache_sid_t sid;
    hpdcache_tid_t tid;
  } hpdcache_req_t;

  function automatic hwpf_line_t hwpf_line(
    input hwpf_addr_t  addr,
    input int unsigned off_w
  );
    return hwpf_line_t'(addr >> off_w);
  endfunction

  function automatic hwpf_addr_t hwpf_line_base(
    input hwpf_line_t  line,
    input int unsigned off_w
  );
    return hwpf_addr_t'(line << off_w);
  endfunction

endpackage

// File: rtl/hwpf_req_fifo.sv
// hwpf_req_fifo: circular request buffer with per-entry valid,
// single-cycle flush and a parallel line-match lookup.
module hwpf_req_fifo
  import hwpf_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned OFF_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  hpdcache_req_t entry_i,
  input  logic          pop_i,
  output hpdcache_req_t head_o,
  output logic          empty_o,
  output logic          full_o,
  input  hwpf_line_t    match_line_i,
  output logic          match_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  hpdcache_req_t    mem_q [DEPTH];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      vld_d = '0;
    end else begin
      if (pop_i) begin
        vld_d[rd_q] = 1'b0;
        rd_d        = rd_q + AW'(1);
      end
      if (push_i) begin
        vld_d[wr_q] = 1'b1;
        wr_d        = wr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(push_i)
                    - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= entry_i;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] &&
          hwpf_line(mem_q[i].addr, OFF_W)
            == match_line_i) begin
        match_o = 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/hwpf_arbiter.sv
// hwpf_arbiter: round-robin merge of prefetcher requests onto the
// single HPDcache prefetch port, with duplicate-line filtering.
module hwpf_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned   NUM_HWPF   = 4,
  parameter int unsigned   FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned   LINE_BYTES = LINE_BYTES_DEF,
  parameter hpdcache_sid_t HWPF_SID   = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                lock_i,
  input  logic [NUM_HWPF-1:0] hwpf_req_valid_i,
  output logic [NUM_HWPF-1:0] hwpf_req_ready_o,
  input  hpdcache_req_t       hwpf_req_i [NUM_HWPF],
  output logic                dcache_req_valid_o,
  input  logic                dcache_req_ready_i,
  output hpdcache_req_t       dcache_req_o,
  output logic                dup_drop_o
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned RR_W  =
    (NUM_HWPF > 1) ? $clog2(NUM_HWPF) : 1;

  logic [RR_W-1:0] rr_q, rr_d, gnt_idx;
  logic            gnt_any;
  hwpf_line_t      last_line_q, last_line_d;
  logic            last_vld_q, last_vld_d;
  logic            dup_q, dup_d;

  hpdcache_req_t   req, entry, head;
  hwpf_line_t      req_line;
  logic            accept, dup, push, pop, issue;
  logic            empty, full, fifo_match;
  logic            unused_req;

  // Grant looks only at valids and rr_q, never at ready.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(NUM_HWPF); k++) begin
      if (!gnt_any &&
          hwpf_req_valid_i[(int'(rr_q) + k)
                           % int'(NUM_HWPF)]) begin
        gnt_any = 1'b1;
        gnt_idx = RR_W'((int'(rr_q) + k)
                        % int'(NUM_HWPF));
      end
    end
  end

  assign req      = hwpf_req_i[gnt_idx];
  assign req_line = hwpf_line(req.addr, OFF_W);

  assign accept = rst_ni & gnt_any & ~full
                & ~lock_i & ~flush_i;
  assign dup    = fifo_match
                | (last_vld_q & (last_line_q == req_line));
  assign push   = accept & ~dup;
  assign issue  = rst_ni & ~empty & ~lock_i & ~flush_i;
  assign pop    = issue & dcache_req_ready_i;

  always_comb begin
    hwpf_req_ready_o = '0;
    if (accept) begin
      hwpf_req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    entry      = '0;
    entry.addr = hwpf_line_base(req_line, OFF_W);
    entry.op   = req.op;
    entry.sid  = HWPF_SID;
  end

  always_comb begin
    rr_d        = rr_q;
    last_line_d = last_line_q;
    last_vld_d  = last_vld_q;
    dup_d       = accept & dup;
    if (accept) begin
      rr_d = (gnt_idx == RR_W'(NUM_HWPF - 1))
           ? '0 : gnt_idx + RR_W'(1);
    end
    if (flush_i) begin
      last_vld_d = 1'b0;
    end else if (pop) begin
      last_line_d = hwpf_line(head.addr, OFF_W);
      last_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      last_line_q <= '0;
      last_vld_q  <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      last_line_q <= last_line_d;
      last_vld_q  <= last_vld_d;
      dup_q       <= dup_d;
    end
  end

  hwpf_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .OFF_W (OFF_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (push),
    .entry_i      (entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .full_o       (full),
    .match_line_i (req_line),
    .match_o      (fifo_match)
  );

  assign dcache_req_valid_o = issue;
  assign dcache_req_o       = rst_ni ? head : '0;
  assign dup_drop_o         = rst_ni & dup_q;

  always_comb begin
    unused_req = 1'b0;
    for (int k = 0; k < int'(NUM_HWPF); k++) begin
      unused_req ^= ^{hwpf_req_i[k].uncacheable,
                      hwpf_req_i[k].need_rsp,
                      hwpf_req_i[k].sid,
                      hwpf_req_i[k].tid};
    end
  end

endmodule

// File: tb/tb_hwpf_arbiter.sv
// tb_hwpf_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hwpf_arbiter;
  import hwpf_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n, flush, lock, ready_i;
  logic [3:0]    vld;
  hpdcache_req_t req [4];
  logic [3:0]    rdy;
  logic          dv, dup;
  hpdcache_req_t dq;

  int n_chk, n_err;

  hwpf_arbiter #(
    .NUM_HWPF   (4),
    .FIFO_DEPTH (4),
    .LINE_BYTES (64),
    .HWPF_SID   ('0)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .lock_i             (lock),
    .hwpf_req_valid_i   (vld),
    .hwpf_req_ready_o   (rdy),
    .hwpf_req_i         (req),
    .dcache_req_valid_o (dv),
    .dcache_req_ready_i (ready_i),
    .dcache_req_o       (dq),
    .dup_drop_o         (dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: buffered requests as a queue, plain integers.
  hpdcache_req_t mq [$];
  logic [31:0]   ilog [$];
  int            m_rr, m_g;
  bit            m_lv, m_dp, m_found, m_acc, m_ev, m_isdup;
  logic [31:0]   m_ll, m_line;
  hpdcache_req_t m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 64'(rdy), 64'(0));
      chk("rst_valid", 64'(dv), 64'(0));
      chk("rst_req", 64'(dq), 64'(0));
      chk("rst_dup", 64'(dup), 64'(0));
      mq.delete();
      m_rr = 0;
      m_lv = 0;
      m_dp = 0;
    end else begin
      m_found = 0;
      m_g     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!m_found && vld[(m_rr + k) % 4]) begin
          m_found = 1;
          m_g     = (m_rr + k) % 4;
        end
      end
      m_acc = m_found && mq.size() < 4 && !lock && !flush;
      m_ev  = mq.size() != 0 && !lock && !flush;
      chk("ready", 64'(rdy),
          m_acc ? 64'(1) << m_g : 64'(0));
      chk("valid", 64'(dv), 64'(m_ev));
      if (m_ev) chk("req", 64'(dq), 64'(mq[0]));
      chk("dup_drop", 64'(dup), 64'(m_dp));
      m_line  = req[m_g].addr / 64;
      m_isdup = 0;
      foreach (mq[i])
        if (mq[i].addr / 64 == m_line) m_isdup = 1;
      if (m_lv && m_ll == m_line) m_isdup = 1;
      m_dp = m_acc && m_isdup;
      if (m_acc) m_rr = (m_g + 1) % 4;
      if (flush) begin
        mq.delete();
        m_lv = 0;
      end else begin
        if (m_ev && ready_i) begin
          ilog.push_back(mq[0].addr);
          m_ll = mq[0].addr / 64;
          m_lv = 1;
          void'(mq.pop_front());
        end
        if (m_acc && !m_isdup) begin
          m_e      = '0;
          m_e.addr = m_line * 64;
          m_e.op   = req[m_g].op;
          mq.push_back(m_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic send(input int p, input logic [31:0] a);
    vld         = '0;
    vld[p]      = 1'b1;
    req[p].addr = a;
    req[p].op   = 4'(p + 1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    vld     = '0;
    flush   = 1'b0;
    lock    = 1'b0;
    ready_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    ilog.delete();
  endtask

  function automatic logic [31:0] lg(input int k);
    return (k < ilog.size()) ? ilog[k] : 32'hdeadbeef;
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) begin
      req[i]      = '0;
      req[i].addr = 32'(i * 64);
    end
    rst_n   = 1'b0;
    vld     = '0;
    flush   = 1'b0;
    lock    = 1'b0;
    ready_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Single request, line-aligned, issued next cycle.
    ready_i = 1'b1;
    send(0, 32'h1044);
    at_neg();
    chk("t1_ready0", 64'(rdy[0]), 64'(1));
    step();
    vld = '0;
    at_neg();
    chk("t1_valid", 64'(dv), 64'(1));
    chk("t1_addr", 64'(dq.addr), 64'h1040);
    chk("t1_need_rsp", 64'(dq.need_rsp), 64'(0));
    chk("t1_uncache", 64'(dq.uncacheable), 64'(0));
    step();
    step();

    // Round-robin fill to full, then in-order drain.
    do_reset();
    for (int i = 0; i < 4; i++)
      req[i].addr = 32'h3000 + 32'(i * 64);
    vld = 4'hf;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("t2_grant", 64'(rdy), 64'(1) << k);
      step();
      vld[k] = 1'b0;
    end
    send(0, 32'h3100);
    at_neg();
    chk("t2_full", 64'(rdy), 64'(0));
    step();
    vld     = '0;
    ready_i = 1'b1;
    repeat (6) step();
    chk("t2_count", 64'(ilog.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      chk("t2_order", 64'(lg(k)),
          64'h3000 + 64'(k * 64));

    // Duplicate against FIFO entry and against last issued line.
    do_reset();
    send(1, 32'h2000);
    at_neg();
    chk("t3_acc1", 64'(rdy), 64'h2);
    step();
    send(2, 32'h2020);
    at_neg();
    chk("t3_acc2", 64'(rdy), 64'h4);
    step();
    vld     = '0;
    ready_i = 1'b1;
    at_neg();
    chk("t3_dup1", 64'(dup), 64'(1));
    chk("t3_valid", 64'(dv), 64'(1));
    step();
    send(0, 32'h2000);
    at_neg();
    chk("t3_acc3", 64'(rdy), 64'h1);
    step();
    vld = '0;
    at_neg();
    chk("t3_dup2", 64'(dup), 64'(1));
    chk("t3_empty", 64'(dv), 64'(0));
    repeat (3) step();
    chk("t3_count", 64'(ilog.size()), 64'(1));
    chk("t3_addr", 64'(lg(0)), 64'h2000);

    // Lock holds contents and pointer for 5 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(i, 32'h4000 + 32'(i * 64));
      step();
    end
    lock = 1'b1;
    send(3, 32'h40c0);
    repeat (5) begin
      at_neg();
      chk("t4_lock_valid", 64'(dv), 64'(0));
      chk("t4_lock_ready", 64'(rdy), 64'(0));
      step();
    end
    lock    = 1'b0;
    ready_i = 1'b1;
    at_neg();
    chk("t4_acc3", 64'(rdy), 64'h8);
    step();
    vld = '0;
    repeat (6) step();
    chk("t4_count", 64'(ilog.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      chk("t4_order", 64'(lg(k)),
          64'h4000 + 64'(k * 64));

    // Flush drops entries and the last-issued line.
    do_reset();
    ready_i = 1'b1;
    send(0, 32'h1040);
    step();
    vld = '0;
    step();
    step();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(i, 32'h5000 + 32'(i * 64));
      step();
    end
    flush = 1'b1;
    send(3, 32'h6000);
    at_neg();
    chk("t5_flush_ready", 64'(rdy), 64'(0));
    chk("t5_flush_valid", 64'(dv), 64'(0));
    step();
    flush = 1'b0;
    vld   = '0;
    at_neg();
    chk("t5_empty", 64'(dv), 64'(0));
    step();
    send(1, 32'h1040);
    at_neg();
    chk("t5_acc", 64'(rdy), 64'h2);
    step();
    vld = '0;
    at_neg();
    chk("t5_nodup", 64'(dup), 64'(0));
    chk("t5_valid", 64'(dv), 64'(1));
    chk("t5_addr", 64'(dq.addr), 64'h1040);
    chk("t5_issued", 64'(lg(0)), 64'h1040);
    step();

    // Reset while requests are buffered.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(i, 32'h7000 + 32'(i * 64));
      step();
    end
    vld = '0;
    at_neg();
    chk("t6_valid_pre", 64'(dv), 64'(1));
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++)
      req[i].addr = 32'h7100 + 32'(i * 64);
    vld = 4'hf;
    step();
    at_neg();
    chk("t6_rst_valid", 64'(dv), 64'(0));
    chk("t6_rst_ready", 64'(rdy), 64'(0));
    chk("t6_rst_req", 64'(dq), 64'(0));
    step();
    rst_n = 1'b1;
    at_neg();
    chk("t6_rr_zero", 64'(rdy), 64'h1);
    chk("t6_empty", 64'(dv), 64'(0));
    step();
    vld = '0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hwpf_arbiter.md
# hwpf_arbiter

Collects prefetch requests from up to NUM_HWPF hardware prefetchers (next-line, stride, etc.) and issues them one at a time on the single HPDcache prefetch request port. Each prefetcher is a valid/ready initiator driving hpdcache_req_t; this block is their common responder. It buffers accepted requests in a small FIFO, arbitrates round-robin, drops duplicate cache lines, and honours the core's flush and lock controls.

## Interface
- NUM_HWPF, 4, number of prefetcher request ports (1..8)
- FIFO_DEPTH, 4, request buffer entries (power of two, ≥2)
- LINE_BYTES, 64, cache line size in bytes (power of two)
- HWPF_SID, 0, source ID driven on every issued request
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, synchronous and active-low
- flush_i  in  1  discard all buffered requests
- lock_i  in  1  stop accepting and issuing
- hwpf_req_valid_i  in  [NUM_HWPF]  per-prefetcher request valid
- hwpf_req_ready_o  out  [NUM_HWPF]  per-prefetcher accept
- hwpf_req_i  in  hpdcache_req_t [NUM_HWPF]  per-prefetcher request
- dcache_req_valid_o  out  1  request to the cache valid
- dcache_req_ready_i  in  1  cache accepts request
- dcache_req_o  out  hpdcache_req_t  issued request
- dup_drop_o  out  1  one-cycle pulse when an accepted request is discarded as a duplicate

## Operation
- Line address: addr >> log2(LINE_BYTES). All comparisons use line addresses.
- Arbitration: round-robin pointer rr_q (0 after reset). The grantee is the first valid port at or after rr_q, modulo NUM_HWPF. The grant depends only on valid and rr_q, never on ready.
- Accept: hwpf_req_ready_o[g] = grant[g] & ~full & ~lock_i & ~flush_i. All other ready outputs are 0. When a request is accepted, rr_q becomes g+1 mod NUM_HWPF.
- Duplicate filter: an accepted request whose line matches any valid FIFO entry (the head included, even if it is popping this cycle) or last_line_q (the most recently issued line, when last_vld_q is set) is discarded. It is not enqueued, and dup_drop_o is pulsed in the next cycle. Otherwise the request is enqueued.
- Enqueued entry fields: line-aligned addr (low log2(LINE_BYTES) bits zeroed), op unchanged, uncacheable=0, need_rsp=0, sid=HWPF_SID, tid='0.
- Issue: dcache_req_valid_o = ~empty & ~lock_i & ~flush_i. dcache_req_o shows the head entry. A handshake (valid & ready) pops the head and loads last_line_q/last_vld_q.
- Lock: no accept and no issue. Contents and rr_q are held.
- Flush: all entries are invalidated and last_vld_q is cleared in one cycle. rr_q is held. Valid and ready outputs are 0 in the flush cycle. Flush has priority over a same-cycle push and pop.

## Timing
- Reset: FIFO empty, rr_q=0, last_vld_q=0. While rst_ni=0, every output is 0 (including dcache_req_o) and all hwpf_req_ready_o are 0.
- Latency: a request accepted in cycle N can be issued at N+1 at the earliest. There is no combinational path from hwpf_req_i to dcache_req_o.
- Full: ready stays 0 even if a pop occurs in the same cycle, so there is no push-through-pop when full. Push and pop in the same cycle are legal when the FIFO is not full. The count stays unchanged.
- Empty: dcache_req_valid_o=0. There is no bypass.
- Wrap-around: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty comes from a count of width log2(FIFO_DEPTH)+1.
- Once dcache_req_valid_o is asserted, the head request is held stable until the handshake, unless lock_i or flush_i intervenes. A flush removes the request. A lock deasserts valid but retains the request.
- Reset mid-operation: synchronous return to the reset state at the next edge, with in-flight entries lost.

## Structure
- hwpf_pkg: hwpf_line_t, the line-address helper function, and the default LINE_BYTES/FIFO_DEPTH constants. It is shared with the prefetchers.
- Sub-module hwpf_req_fifo: a circular buffer with push/pop/flush, per-entry valid, and the parallel line-match output. The arbiter, filter and last-issued register stay in hwpf_arbiter.

## Test plan
- Reset, then port 0 sends addr 0x1044 with dcache_req_ready_i=1: ready_o[0] is 1 in cycle 0, and in cycle 1 valid_o=1 with addr=0x1040, need_rsp=0, uncacheable=0.
- Ports 0–3 all hold valid with distinct lines and dcache_req_ready_i=0: grants go 0, 1, 2, 3. After 4 accepts all readies are 0 (full). Once ready_i=1, the issue order is 0, 1, 2, 3.
- Port 1 sends 0x2000, then port 2 sends 0x2020 while 0x2000 is buffered: the second request is accepted, dup_drop_o pulses, and exactly one 0x2000 is issued. Resending 0x2000 right after its issue is also dropped (last_line_q match).
- 3 entries buffered, then lock_i held for 5 cycles: no valid and no ready. After release, the 3 entries issue in order with no loss.
- 3 entries buffered, then flush_i for 1 cycle with a same-cycle port request: the FIFO is empty, nothing is issued, and the next 0x1040 request is not treated as a duplicate.
- Reset asserted while 2 entries are buffered and valid_o=1: at the next edge all outputs are 0 and rr_q=0.
